// File: rtl/serial_tx_pkg.sv
// Shared state encoding, mode codes, PRBS7 definition and line levels
// for the framed serial transmitter.
package serial_tx_pkg;

  typedef enum logic [2:0] {
    ST_TRAIN      = 3'd0,
    ST_IDLE       = 3'd1,
    ST_START      = 3'd2,
    ST_DATA       = 3'd3,
    ST_STOP       = 3'd4,
    ST_PRBS       = 3'd5,
    ST_TRAIN_CONT = 3'd6
  } tx_state_e;

  localparam logic [1:0] MODE_DATA  = 2'd0;
  localparam logic [1:0] MODE_PRBS  = 2'd1;
  localparam logic [1:0] MODE_TRAIN = 2'd2;
  localparam logic [1:0] MODE_IDLE  = 2'd3;

  localparam int         PRBS_W      = 7;
  localparam logic [6:0] PRBS_SEED   = 7'h7F;
  localparam int         PRBS_TAP_HI = 6;
  localparam int         PRBS_TAP_LO = 5;

  localparam logic START_LVL = 1'b0;
  localparam logic STOP_LVL  = 1'b1;
  localparam logic IDLE_LVL  = 1'b1;

  // x^7 + x^6 + 1, shifting towards the MSB which drives the line.
  function automatic logic [6:0] prbs7_next(input logic [6:0] s);
    return {s[5:0], s[PRBS_TAP_HI] ^ s[PRBS_TAP_LO]};
  endfunction

endpackage

// File: rtl/tx_byte_fifo.sv
// Small first-word-fall-through byte FIFO; head entry is visible on data_o
// so the transmitter can load its shift register on the pop cycle.
module tx_byte_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] data_o,
  output logic              full_o,
  output logic              empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q;
  logic [AW-1:0]     rd_ptr_q;
  logic [AW:0]       count_q;
  logic              push_ok;
  logic              pop_ok;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign data_o  = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/serial_frame_transmitter.sv
// Framed NRZ transmitter with post-reset training, PRBS7 and continuous
// training test modes. state_q always names the bit currently on the line.
module serial_frame_transmitter
  import serial_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4,
  parameter int DATA_W       = 8,
  parameter int FIFO_DEPTH   = 4,
  parameter int TRAIN_BITS   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              serial_out,
  output logic              bit_strobe,
  output logic              busy
);

  localparam int CW     = $clog2(CLKS_PER_BIT);
  localparam int BC_MAX = (TRAIN_BITS > DATA_W) ? TRAIN_BITS : DATA_W;
  localparam int BW     = $clog2(BC_MAX);
  localparam logic [CW-1:0] CNT_LAST   = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] TRAIN_LAST = BW'(TRAIN_BITS - 1);
  localparam logic [BW-1:0] DATA_LAST  = BW'(DATA_W - 1);

  tx_state_e           state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [BW-1:0]       bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0]   shreg_q, shreg_d;
  logic [PRBS_W-1:0]   lfsr_q, lfsr_d;
  logic                line_q, line_d;
  logic                boundary;
  logic                pop;
  logic                fifo_full;
  logic                fifo_empty;
  logic [DATA_W-1:0]   fifo_data;

  tx_byte_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (s_valid),
    .data_i  (s_data),
    .pop_i   (pop),
    .data_o  (fifo_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign boundary   = (cnt_q == CNT_LAST);
  assign cnt_d      = boundary ? '0 : cnt_q + 1'b1;
  assign bit_strobe = boundary;
  assign serial_out = line_q;
  assign s_ready    = !fifo_full;
  assign busy       = (state_q == ST_TRAIN) || (state_q == ST_START) ||
                      (state_q == ST_DATA)  || (state_q == ST_STOP)  || !fifo_empty;

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_TRAIN;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (boundary) begin
      case (state_q)
        ST_TRAIN: if (bit_cnt_q == TRAIN_LAST) state_d = ST_IDLE;
        ST_IDLE: begin
          case (mode)
            MODE_DATA:  if (!fifo_empty) state_d = ST_START;
            MODE_PRBS:  state_d = ST_PRBS;
            MODE_TRAIN: state_d = ST_TRAIN_CONT;
            MODE_IDLE:  state_d = ST_IDLE;
          endcase
        end
        ST_START: state_d = ST_DATA;
        ST_DATA:  if (bit_cnt_q == DATA_LAST) state_d = ST_STOP;
        // Mode is only honoured once the stop bit is out.
        ST_STOP:  state_d = (mode == MODE_DATA && !fifo_empty) ? ST_START : ST_IDLE;
        ST_PRBS:  if (mode != MODE_PRBS) state_d = ST_IDLE;
        ST_TRAIN_CONT: if (mode != MODE_TRAIN) state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    line_d    = line_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    lfsr_d    = lfsr_q;
    pop       = 1'b0;
    if (boundary) begin
      if (state_q == ST_PRBS) lfsr_d = prbs7_next(lfsr_q);
      case (state_d)
        ST_TRAIN: begin
          line_d    = ~line_q;
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
        ST_START: begin
          line_d    = START_LVL;
          pop       = 1'b1;
          shreg_d   = fifo_data;
          bit_cnt_d = '0;
        end
        ST_DATA: begin
          if (state_q == ST_START) begin
            line_d = shreg_q[0];
          end else begin
            shreg_d   = shreg_q >> 1;
            line_d    = shreg_q[1];
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
        ST_STOP:       line_d = STOP_LVL;
        ST_PRBS:       line_d = lfsr_d[PRBS_W-1];
        ST_TRAIN_CONT: line_d = (state_q == ST_TRAIN_CONT) ? ~line_q : 1'b1;
        default: begin
          line_d    = IDLE_LVL;
          bit_cnt_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      lfsr_q    <= PRBS_SEED;
      line_q    <= IDLE_LVL;
    end else begin
      cnt_q     <= cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      lfsr_q    <= lfsr_d;
      line_q    <= line_d;
    end
  end

endmodule

// File: tb/tb_serial_frame_transmitter.sv
// Scenario bench for serial_frame_transmitter: expected line bits are queued
// when stimulus is applied and compared against bits sampled at bit_strobe.
module tb_serial_frame_transmitter;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] mode;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_ready;
  logic       serial_out;
  logic       bit_strobe;
  logic       busy;

  int n_vec = 0;
  int n_err = 0;

  bit exp_q[$];
  bit obs_q[$];
  bit mon_en = 1'b0;
  bit mon_started = 1'b0;

  serial_frame_transmitter #(
    .CLKS_PER_BIT (4),
    .DATA_W       (8),
    .FIFO_DEPTH   (4),
    .TRAIN_BITS   (32)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .mode       (mode),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .serial_out (serial_out),
    .bit_strobe (bit_strobe),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Line monitor: one sample per bit, optionally skipping idle ones until a start bit.
  always @(negedge clk) begin
    if (mon_en && bit_strobe && (mon_started || serial_out == 1'b0)) begin
      mon_started = 1'b1;
      obs_q.push_back(serial_out);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, n_vec=%0d", n_vec);
    $fatal(1, "watchdog");
  end

  task automatic push_frame_bits(input logic [7:0] b);
    exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_q.push_back(b[i]);
    exp_q.push_back(1'b1);
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic push_byte(input logic [7:0] b, output bit ok);
    int w;
    w = 0;
    s_data = b;
    s_valid = 1'b1;
    while (!s_ready && w < 400) begin @(posedge clk); #1; w++; end
    ok = s_ready;
    @(posedge clk); #1;
    s_valid = 1'b0;
    if (ok) push_frame_bits(b);
  endtask

  task automatic test_reset();
    bit el, es, eb;
    rst = 1'b1; mode = 2'd0; s_valid = 1'b0; s_data = 8'h00;
    repeat (3) begin
      @(negedge clk);
      n_vec++;
      if (serial_out !== 1'b1) begin n_err++; $display("FAIL reset_line: serial_out=%b expected 1", serial_out); end
    end
    n_vec++;
    if ({bit_strobe, busy, s_ready} !== 3'b011) begin
      n_err++; $display("FAIL reset_values: strobe/busy/ready=%b expected 011", {bit_strobe, busy, s_ready});
    end
    @(posedge clk); #1; rst = 1'b0;
    for (int c = 0; c < 140; c++) begin
      @(negedge clk);
      el = (c < 128) ? (((c / 4) % 2) == 0) : 1'b1;
      es = ((c % 4) == 3);
      eb = (c < 128);
      n_vec++;
      if (serial_out !== el) begin n_err++; $display("FAIL train_line c=%0d: got %b expected %b", c, serial_out, el); end
      n_vec++;
      if (bit_strobe !== es) begin n_err++; $display("FAIL train_strobe c=%0d: got %b expected %b", c, bit_strobe, es); end
      n_vec++;
      if (busy !== eb) begin n_err++; $display("FAIL train_busy c=%0d: got %b expected %b", c, busy, eb); end
    end
    $display("reset: 32 training bits and idle checked over 140 cycles");
  endtask

  task automatic test_frame_a5();
    bit ok, e, o;
    int w;
    exp_q.delete(); obs_q.delete(); mon_started = 1'b0; mon_en = 1'b1;
    @(posedge clk); #1;
    push_byte(8'hA5, ok);
    n_vec++;
    if (!ok) begin n_err++; $display("FAIL a5_push: s_ready=%b expected 1", s_ready); end
    n_vec++;
    if (busy !== 1'b1) begin n_err++; $display("FAIL a5_busy_high: got %b expected 1", busy); end
    w = 0;
    while (obs_q.size() < 10 && w < 400) begin @(posedge clk); w++; end
    n_vec++;
    if (obs_q.size() < 10) begin
      n_err++; $display("FAIL a5_timeout: got %0d bits expected 10", obs_q.size());
    end else begin
      for (int i = 0; i < 10; i++) begin
        e = exp_q.pop_front(); o = obs_q.pop_front();
        n_vec++;
        if (o !== e) begin n_err++; $display("FAIL a5_bit%0d: got %b expected %b", i, o, e); end
      end
    end
    @(negedge clk);
    n_vec++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL a5_busy_low: got %b expected 0", busy); end
    mon_en = 1'b0;
    $display("frame: 0xA5 sent, 10 bits compared");
  endtask

  task automatic test_fill_during_train();
    logic [7:0] bytes [5];
    bit prev, e, o;
    int w;
    bytes[0] = 8'h11; bytes[1] = 8'hE2; bytes[2] = 8'h5A; bytes[3] = 8'h80; bytes[4] = 8'h7F;
    exp_q.delete(); obs_q.delete(); mon_en = 1'b0;
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s_data = bytes[i]; s_valid = 1'b1;
      n_vec++;
      if (s_ready !== 1'b1) begin n_err++; $display("FAIL fill_ready%0d: got %b expected 1", i, s_ready); end
      push_frame_bits(bytes[i]);
      @(posedge clk); #1;
    end
    s_data = bytes[4];
    n_vec++;
    if (s_ready !== 1'b0) begin n_err++; $display("FAIL fill_full: s_ready=%b expected 0", s_ready); end
    w = 0; prev = serial_out;
    while (!s_ready && w < 300) begin prev = serial_out; @(posedge clk); #1; w++; end
    n_vec++;
    if (!s_ready) begin n_err++; $display("FAIL fill_ready_timeout: s_ready=%b expected 1", s_ready); end
    n_vec++;
    if (w != 128) begin n_err++; $display("FAIL fill_accept_cycle: got %0d expected 128", w); end
    n_vec++;
    if (serial_out !== 1'b0 || prev !== 1'b1) begin
      n_err++; $display("FAIL fill_pop_timing: line %b->%b expected 1->0", prev, serial_out);
    end
    obs_q.delete(); mon_started = 1'b0; mon_en = 1'b1;
    push_frame_bits(bytes[4]);
    @(posedge clk); #1; s_valid = 1'b0;
    w = 0;
    while (obs_q.size() < 50 && w < 400) begin @(posedge clk); w++; end
    n_vec++;
    if (obs_q.size() < 50) begin
      n_err++; $display("FAIL fill_timeout: got %0d bits expected 50", obs_q.size());
    end else begin
      for (int i = 0; i < 50; i++) begin
        e = exp_q.pop_front(); o = obs_q.pop_front();
        n_vec++;
        if (o !== e) begin n_err++; $display("FAIL b2b_bit%0d: got %b expected %b", i, o, e); end
      end
    end
    mon_en = 1'b0;
    $display("back_to_back: 5 frames queued during training, 50 bits compared");
  endtask

  task automatic test_prbs();
    bit got [255];
    bit e;
    logic [6:0] m;
    int w, ones;
    mon_en = 1'b0; w = 0;
    do begin @(negedge clk); w++; end while (!bit_strobe && w < 16);
    @(posedge clk); #1; mode = 2'd1;
    obs_q.delete(); exp_q.delete(); mon_started = 1'b1; mon_en = 1'b1;
    exp_q.push_back(1'b1);
    m = 7'h7F;
    for (int i = 0; i < 254; i++) begin exp_q.push_back(m[6]); m = {m[5:0], m[6] ^ m[5]}; end
    w = 0;
    while (obs_q.size() < 255 && w < 1300) begin @(posedge clk); w++; end
    mon_en = 1'b0;
    n_vec++;
    if (obs_q.size() < 255) begin
      n_err++; $display("FAIL prbs_timeout: got %0d bits expected 255", obs_q.size());
    end else begin
      for (int i = 0; i < 255; i++) begin
        got[i] = obs_q.pop_front(); e = exp_q.pop_front();
        n_vec++;
        if (got[i] !== e) begin n_err++; $display("FAIL prbs_bit%0d: got %b expected %b", i, got[i], e); end
      end
      ones = 0;
      for (int i = 1; i < 128; i++) ones += int'(got[i]);
      n_vec++;
      if (ones != 64) begin n_err++; $display("FAIL prbs_ones: got %0d expected 64", ones); end
    end
    #1; mode = 2'd0; w = 0;
    do begin @(negedge clk); w++; end while (!bit_strobe && w < 16);
    @(posedge clk); #1;
    n_vec++;
    if (serial_out !== 1'b1) begin n_err++; $display("FAIL prbs_exit: got %b expected 1", serial_out); end
    for (int c = 0; c < 32; c++) begin
      @(negedge clk);
      n_vec++;
      if (serial_out !== 1'b1) begin n_err++; $display("FAIL prbs_idle c=%0d: got %b expected 1", c, serial_out); end
    end
    $display("prbs: 254 bits vs x^7+x^6+1 model, exit to idle checked");
  endtask

  task automatic test_mode_mid_frame();
    bit ok, e, o;
    logic [6:0] m;
    int w;
    mon_en = 1'b0;
    @(posedge clk); #1; rst = 1'b1; mode = 2'd0;
    @(posedge clk); #1; rst = 1'b0;
    w = 0;
    while (busy && w < 200) begin @(posedge clk); #1; w++; end
    n_vec++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL mid_train_end: busy=%b expected 0", busy); end
    obs_q.delete(); exp_q.delete(); mon_started = 1'b0; mon_en = 1'b1;
    push_byte(8'h3C, ok);
    n_vec++;
    if (!ok) begin n_err++; $display("FAIL mid_push: s_ready=%b expected 1", s_ready); end
    w = 0;
    while (obs_q.size() < 4 && w < 100) begin @(posedge clk); w++; end
    #1; mode = 2'd1;
    exp_q.push_back(1'b1);
    m = 7'h7F;
    for (int i = 0; i < 16; i++) begin exp_q.push_back(m[6]); m = {m[5:0], m[6] ^ m[5]}; end
    w = 0;
    while (obs_q.size() < 27 && w < 300) begin @(posedge clk); w++; end
    n_vec++;
    if (obs_q.size() < 27) begin
      n_err++; $display("FAIL mid_timeout: got %0d bits expected 27", obs_q.size());
    end else begin
      for (int i = 0; i < 27; i++) begin
        e = exp_q.pop_front(); o = obs_q.pop_front();
        n_vec++;
        if (o !== e) begin n_err++; $display("FAIL mid_bit%0d: got %b expected %b", i, o, e); end
      end
    end
    mon_en = 1'b0;
    $display("mode_mid_frame: 0x3C completes, idle bit, then PRBS from seed");
  endtask

  task automatic test_reset_mid_frame();
    bit ok, e, o, el, eb;
    int w;
    @(posedge clk); #1; mode = 2'd0;
    repeat (12) @(posedge clk);
    #1;
    obs_q.delete(); exp_q.delete(); mon_started = 1'b0; mon_en = 1'b1;
    push_byte(8'h55, ok);
    push_byte(8'h0F, ok);
    push_byte(8'hF0, ok);
    w = 0;
    while (obs_q.size() < 6 && w < 200) begin @(posedge clk); w++; end
    #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0; mon_en = 1'b0;
    n_vec++;
    if ({serial_out, s_ready, busy, bit_strobe} !== 4'b1110) begin
      n_err++; $display("FAIL rstmid_values: line/ready/busy/strobe=%b expected 1110",
                        {serial_out, s_ready, busy, bit_strobe});
    end
    n_vec++;
    if (obs_q.size() < 6) begin
      n_err++; $display("FAIL rstmid_prefix: got %0d bits expected 6", obs_q.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        e = exp_q.pop_front(); o = obs_q.pop_front();
        n_vec++;
        if (o !== e) begin n_err++; $display("FAIL rstmid_bit%0d: got %b expected %b", i, o, e); end
      end
    end
    for (int c = 0; c < 176; c++) begin
      @(negedge clk);
      el = (c < 128) ? (((c / 4) % 2) == 0) : 1'b1;
      eb = (c < 128);
      n_vec++;
      if (serial_out !== el) begin n_err++; $display("FAIL retrain_line c=%0d: got %b expected %b", c, serial_out, el); end
      n_vec++;
      if (busy !== eb) begin n_err++; $display("FAIL retrain_busy c=%0d: got %b expected %b", c, busy, eb); end
    end
    $display("reset_mid_frame: frame aborted, FIFO flushed, training restarted");
  endtask

  initial begin
    test_reset();
    test_frame_a5();
    test_fill_during_train();
    test_prbs();
    test_mode_mid_frame();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
